fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch front end that sits directly upstream of the single-cycle instruction memory.
- Owns the program counter and drives the word-aligned byte address to the memory's combinational read port.
- Captures each returned instruction with its PC into a small FIFO, presented to decode via a valid/ready handshake.
- Supports stall by back-pressure, redirect (branch/jump) with flush, and halt.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset; bits [1:0] must be 0.
DEPTH, 2, fetch FIFO entries; power of two, >= 2.
NOP_INSTR, 32'h00000033, value driven on out_instr when FIFO is empty (add x0,x0,x0).

Ports:
clk  input  1  system clock, all state on rising edge.
rst_n  input  1  asynchronous, active-low reset.
imem_addr  output  32  byte address to instruction memory; always equals pc_q.
imem_rdata  input  32  instruction returned combinationally for imem_addr in the same cycle.
redirect_valid  input  1  load new PC and flush FIFO this cycle.
redirect_pc  input  32  redirect target; bits [1:0] ignored (forced 0).
halt_req  input  1  stop fetching after the current cycle.
out_valid  output  1  FIFO head holds a valid instruction.
out_ready  input  1  downstream accepts head this cycle.
out_instr  output  32  head instruction, or NOP_INSTR when empty.
out_pc  output  32  PC of head instruction, or 0 when empty.
halted  output  1  high while in HALTED state.

Behaviour:
- Reset (async assert, rst_n=0):
  - pc_q=RESET_PC, FIFO count=0, read/write pointers=0, state=IDLE.
  - out_valid=0, out_instr=NOP_INSTR, out_pc=0, halted=0.
- States: IDLE, FETCH, HALTED.
  - IDLE: no push; next cycle -> FETCH. Gives one bubble after reset release so the first fetch uses a stable pc_q.
  - FETCH: push enabled. halt_req=1 -> HALTED at the clock edge; the push in that same cycle still occurs.
  - HALTED: no push, pc_q holds, halted=1, FIFO keeps draining to downstream. Exit only via redirect (-> FETCH) or reset.
- Push rule (FETCH only, no redirect):
  - push = (count<DEPTH) || (out_valid && out_ready).
  - On push: entry {pc_q, imem_rdata} written at write pointer; pc_q <= pc_q+4.
  - PC arithmetic is modulo 2^32: 32'hFFFFFFFC wraps to 0.
  - No push -> pc_q holds (stall).
- Pop rule: pop = out_valid && out_ready; read pointer advances.
  - Simultaneous push and pop: count unchanged, valid even when full or when count==1.
  - Pop without push -> count-1; push without pop -> count+1; count never exceeds DEPTH or underflows.
- Output: out_valid = (count!=0); out_instr/out_pc driven combinationally from head entry. Fetch-to-output latency is 1 cycle (entry visible the cycle after capture).
- Redirect (highest priority, any state except IDLE):
  - FIFO flushed (count=0, pointers=0); no push that cycle.
  - pc_q <= {redirect_pc[31:2],2'b00}; state -> FETCH.
  - A pop in the same cycle is still treated as accepted by downstream; the flushed contents are discarded.
  - Redirect beats halt_req when both are asserted.
  - redirect_valid in IDLE is ignored.
- Reset mid-operation: immediate return to reset values regardless of state or FIFO contents.
- No X propagation: empty-FIFO outputs are constants as specified.

Test Plan:
- Reset release, out_ready=1, memory holding 0x11,0x22,0x33: imem_addr 0,0,4,8 on cycles 0..3 (IDLE bubble on cycle 0); out_instr 0x11@pc0, 0x22@pc4, 0x33@pc8 on consecutive cycles after the first valid.
- out_ready=0 from start (DEPTH=2): exactly 2 pushes (pc 0,4), then pc_q held at 8 and out_valid stays 1. Raise out_ready: entries pc0, pc4, pc8 emitted in order, none dropped or duplicated.
- Redirect to 0x103 with FIFO full: next cycle out_valid=0, imem_addr=0x100; following cycle out_pc=0x100.
- halt_req pulse at pc=0x10 with out_ready=1: entry 0x10 still delivered; halted=1 and imem_addr frozen at 0x14. Redirect to 0x40 clears halted and resumes fetch from 0x40.
- RESET_PC=32'hFFFFFFF8: fetched PCs are FFFFFFF8, FFFFFFFC, 00000000, 00000004.
- Assert rst_n=0 mid-stream with FIFO at count=1: outputs return to reset values asynchronously; after release, fetch restarts at RESET_PC with the IDLE bubble.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and fetch FIFO between the instruction memory and decode,
// with back-pressure stall, redirect flush and halt.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h00000033
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q;
  logic [AW:0] count_q;
  logic [AW-1:0] rd_q, wr_q;
  logic [31:0] pc_mem [DEPTH];
  logic [31:0] instr_mem [DEPTH];
  logic redirect, push, pop;
  always_comb begin
    redirect = redirect_valid && state_q != IDLE;
    pop      = out_valid && out_ready;
    push     = state_q == FETCH && !redirect && (count_q < (AW+1)'(DEPTH) || pop);
    state_d  = state_q == IDLE ? FETCH :
               redirect ? FETCH :
               (state_q == FETCH && halt_req) ? HALTED : state_q;
  end
  assign imem_addr = pc_q;
  assign out_valid = count_q != '0;
  assign out_instr = out_valid ? instr_mem[rd_q] : NOP_INSTR;
  assign out_pc    = out_valid ? pc_mem[rd_q] : 32'd0;
  assign halted    = state_q == HALTED;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      count_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      if (redirect) begin
        pc_q    <= redirect_pc & ~32'd3;
        count_q <= '0;
        rd_q    <= '0;
        wr_q    <= '0;
      end else begin
        pc_q    <= push ? pc_q + 32'd4 : pc_q;
        count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
        rd_q    <= rd_q + AW'(pop);
        wr_q    <= wr_q + AW'(push);
      end
    end
  end
  // Storage needs no reset: outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_q]    <= pc_q;
      instr_mem[wr_q] <= imem_rdata;
    end
  end
endmodule
